exec_ctrl: RTL and testbench

Execution controller for the single-cycle RISC-V datapath. Drives the datapath's per-instruction advance enable, so software or a debug host can halt, free-run or single-step the core and stop on a PC breakpoint. Sits between a command port (debug/host side) and the datapath's `pc_atual` output. The datapath retires exactly one instruction on every `clk` edge where `cpu_en` is 1.

---
 rtl/exec_ctrl.sv | 139 +++++++++++++
 tb/tb_exec_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/exec_ctrl.sv
// Execution controller: halt / free-run / single-step gating of the datapath advance enable.
// Optional PC breakpoint logic is built when EXEC_CTRL_BREAKPOINT_EN is defined.
module exec_ctrl #(
    parameter int unsigned STEP_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [31:0]       i_cmd_arg,
    input  logic [31:0]       i_pc_atual,
    output logic              o_cpu_en,
    output logic              o_halted,
    output logic              o_bp_hit,
    output logic [STEP_W-1:0] o_steps_left
);

    localparam logic [1:0] OpHalt  = 2'b00;
    localparam logic [1:0] OpRun   = 2'b01;
    localparam logic [1:0] OpStep  = 2'b10;
    localparam logic [1:0] OpSetBp = 2'b11;

    typedef enum logic [1:0] {StHalt, StRun, StStep} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [STEP_W-1:0] r_steps;
    logic [STEP_W-1:0] w_steps_nxt;
    logic              w_cmd_acc;
    logic              w_bp_match;
    logic              w_cpu_en;
    logic [STEP_W-1:0] w_step_k;
    logic              w_unused;

    assign w_step_k = i_cmd_arg[STEP_W-1:0];
    // Without the breakpoint option some inputs have no consumer.
    assign w_unused = ^{i_cmd_arg, i_pc_atual};

`ifdef EXEC_CTRL_BREAKPOINT_EN
    logic [31:0] r_bp_addr;
    logic [31:0] w_bp_addr_nxt;
    logic        r_bp_en;
    logic        w_bp_en_nxt;
    logic        r_skip;
    logic        w_skip_nxt;
    logic        r_bp_hit;
    logic        w_bp_hit_nxt;

    // Skip lets a resume execute the instruction sitting at the breakpoint address.
    assign w_bp_match = r_bp_en & (i_pc_atual == r_bp_addr) & ~r_skip;
    assign o_bp_hit   = r_bp_hit;
`else
    assign w_bp_match = 1'b0;
    assign o_bp_hit   = 1'b0;
`endif

    assign w_cpu_en     = (r_state != StHalt) & ~w_bp_match;
    assign o_cpu_en     = w_cpu_en;
    assign o_halted     = (r_state == StHalt);
    assign o_steps_left = r_steps;
    assign o_cmd_ready  = (r_state == StStep) ? (i_cmd_op == OpHalt) : 1'b1;
    assign w_cmd_acc    = i_cmd_valid & o_cmd_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_steps_nxt = r_steps;
`ifdef EXEC_CTRL_BREAKPOINT_EN
        w_bp_addr_nxt = r_bp_addr;
        w_bp_en_nxt   = r_bp_en;
        w_skip_nxt    = r_skip;
        w_bp_hit_nxt  = r_bp_hit;
        if (w_cpu_en) begin
            w_skip_nxt = 1'b0;
        end
        if (w_cmd_acc && (i_cmd_op == OpSetBp)) begin
            w_bp_addr_nxt = {i_cmd_arg[31:1], 1'b0};
            w_bp_en_nxt   = i_cmd_arg[0];
        end
`endif
        if ((r_state != StHalt) && w_bp_match) begin
            w_state_nxt = StHalt;
            w_steps_nxt = '0;
`ifdef EXEC_CTRL_BREAKPOINT_EN
            w_bp_hit_nxt = 1'b1;
`endif
        end else if (w_cmd_acc && (i_cmd_op == OpHalt)) begin
            w_state_nxt = StHalt;
            w_steps_nxt = '0;
        end else if ((r_state == StStep) && w_cpu_en) begin
            w_steps_nxt = r_steps - STEP_W'(1);
            if (r_steps == STEP_W'(1)) begin
                w_state_nxt = StHalt;
            end
        end else if (w_cmd_acc && (r_state == StHalt)) begin
            if (i_cmd_op == OpRun) begin
                w_state_nxt = StRun;
`ifdef EXEC_CTRL_BREAKPOINT_EN
                w_bp_hit_nxt = 1'b0;
                w_skip_nxt   = 1'b1;
`endif
            end else if ((i_cmd_op == OpStep) && (|w_step_k)) begin
                w_state_nxt = StStep;
                w_steps_nxt = w_step_k;
`ifdef EXEC_CTRL_BREAKPOINT_EN
                w_bp_hit_nxt = 1'b0;
                w_skip_nxt   = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StHalt;
            r_steps <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_steps <= w_steps_nxt;
        end
    end

`ifdef EXEC_CTRL_BREAKPOINT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bp_addr <= '0;
            r_bp_en   <= 1'b0;
            r_skip    <= 1'b0;
            r_bp_hit  <= 1'b0;
        end else begin
            r_bp_addr <= w_bp_addr_nxt;
            r_bp_en   <= w_bp_en_nxt;
            r_skip    <= w_skip_nxt;
            r_bp_hit  <= w_bp_hit_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a tiny PC model (PC += 4 on each enabled edge).
module tb_exec_ctrl;
    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [31:0]       cmd_arg;
    logic [31:0]       pc;
    logic              cpu_en;
    logic              halted;
    logic              bp_hit;
    logic [STEP_W-1:0] steps_left;
    int                retires;
    int                n_checks = 0;
    int                n_errors = 0;
    int                base;

    exec_ctrl #(.STEP_W(STEP_W)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_op     (cmd_op),
        .i_cmd_arg    (cmd_arg),
        .i_pc_atual   (pc),
        .o_cpu_en     (cpu_en),
        .o_halted     (halted),
        .o_bp_hit     (bp_hit),
        .o_steps_left (steps_left)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            pc      <= 32'h0;
            retires <= 0;
        end else if (cpu_en) begin
            pc      <= pc + 32'd4;
            retires <= retires + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 32'h0;
        do_reset();

        // Reset state and idle
        check("rst_halted", halted, 1);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_steps", steps_left, 0);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_ready", cmd_ready, 1);
        repeat (3) cycle();
        check("idle_pc", pc, 32'h0);
        check("idle_retires", retires, 0);

        // STEP 3
        send(2'b10, 32'd3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("step3_en%0d", i), cpu_en, (i < 3) ? 1 : 0);
            check($sformatf("step3_left%0d", i), steps_left, 3 - i);
            cycle();
        end
        check("step3_pc", pc, 32'd12);
        check("step3_halted", halted, 1);
        check("step3_retires", retires, 3);

        // RUN then HALT: five retires
        base = retires;
        send(2'b01, 32'h0);
        check("run_en", cpu_en, 1);
        check("run_halted", halted, 0);
        repeat (4) cycle();
        send(2'b00, 32'h0);
        check("halt_halted", halted, 1);
        check("halt_en", cpu_en, 0);
        check("halt_retires", retires - base, 5);
        cycle();
        check("halt_no_more", retires - base, 5);

        // STEP 100: STEP refused, HALT accepted at once
        send(2'b10, 32'd100);
        check("s100_left", steps_left, 100);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_arg   = 32'd5;
        #1;
        check("s100_step_ready", cmd_ready, 0);
        cycle();
        check("s100_left_after", steps_left, 99);
        cmd_op = 2'b00;
        #1;
        check("s100_halt_ready", cmd_ready, 1);
        cycle();
        cmd_valid = 1'b0;
        check("s100_halted", halted, 1);
        check("s100_steps0", steps_left, 0);

        // Reset mid-STEP 50 clears everything, including a breakpoint
        send(2'b11, 32'h5);
        send(2'b10, 32'd50);
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst50_halted", halted, 1);
        check("rst50_steps", steps_left, 0);
        check("rst50_en", cpu_en, 0);
        send(2'b10, 32'd2);
        repeat (3) cycle();
        check("rst50_bp_cleared_pc", pc, 32'h8);
        base = retires;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_arg   = 32'd0;
        #1;
        check("step0_ready", cmd_ready, 1);
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("step0_en%0d", i), cpu_en, 0);
            cycle();
        end
        check("step0_retires", retires - base, 0);
        check("step0_halted", halted, 1);

        // Breakpoint at 0x10
        do_reset();
        send(2'b11, 32'h11);
        send(2'b01, 32'h0);
`ifdef EXEC_CTRL_BREAKPOINT_EN
        begin
            bit done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                if (halted) done = 1'b1;
                else cycle();
            end
            check("bp_timeout", done, 1);
        end
        check("bp_pc", pc, 32'h10);
        check("bp_hit", bp_hit, 1);
        check("bp_retires", retires, 4);
        check("bp_steps", steps_left, 0);
        send(2'b10, 32'd1);
        check("bp_resume_en", cpu_en, 1);
        cycle();
        check("bp_resume_pc", pc, 32'h14);
        check("bp_resume_hit", bp_hit, 0);
        check("bp_resume_halted", halted, 1);
`else
        repeat (8) cycle();
        check("nobp_pc", pc, 32'h20);
        check("nobp_hit", bp_hit, 0);
        check("nobp_en", cpu_en, 1);
        send(2'b00, 32'h0);
        check("nobp_halted", halted, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
